// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: instruction-register opcode and memory/hazard handshakes in,
// per-state datapath control lines and fault reporting out.
interface multicycle_control_unit_if #(
    parameter int OPW  = 6,
    parameter int ALUW = 6
);
    logic [OPW-1:0]  opcode;
    logic            imem_ready;
    logic            dmem_ready;
    logic            stall;
    logic            pc_write;
    logic            ir_write;
    logic [1:0]      reg_dst;
    logic            jump;
    logic            branch;
    logic [1:0]      mem_read;
    logic [1:0]      mem_write;
    logic            mem_to_reg;
    logic [ALUW-1:0] alu_op;
    logic [1:0]      alu_src;
    logic            reg_write;
    logic            busy;
    logic            fault;
    logic [1:0]      fault_cause;

    modport master (
        input  opcode, imem_ready, dmem_ready, stall,
        output pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write,
               mem_to_reg, alu_op, alu_src, reg_write, busy, fault, fault_cause
    );

    modport slave (
        output opcode, imem_ready, dmem_ready, stall,
        input  pc_write, ir_write, reg_dst, jump, branch, mem_read, mem_write,
               mem_to_reg, alu_op, alu_src, reg_write, busy, fault, fault_cause
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath control lines for the current state only.
module multicycle_control_unit #(
    parameter int OPW         = 6,
    parameter int ALUW        = 6,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_unit_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {C_ILL, C_NOP, C_R, C_IMM, C_BR, C_J, C_JAL, C_LD, C_ST} cls_t;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b000000:                                                  return C_R;
            6'b100000:                                                  return C_NOP;
            6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001101,
            6'b010011:                                                  return C_IMM;
            6'b001010, 6'b001011, 6'b001100:                            return C_BR;
            6'b010101, 6'b010110:                                       return C_J;
            6'b010111:                                                  return C_JAL;
            6'b001110, 6'b001111, 6'b010100:                            return C_LD;
            6'b010000, 6'b010001, 6'b010010:                            return C_ST;
            default:                                                    return C_ILL;
        endcase
    endfunction

    // Load codes are half/word/byte, store codes byte/half/word: both map to 01/10/11.
    function automatic logic [1:0] access_code(input logic [5:0] op);
        case (op)
            6'b001110, 6'b010000: return 2'b01;
            6'b001111, 6'b010001: return 2'b10;
            6'b010100, 6'b010010: return 2'b11;
            default:              return 2'b00;
        endcase
    endfunction

    state_t          state_reg, state_next;
    logic [5:0]      op_reg, op_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      cause_reg, cause_next;

    logic            upper_nz;
    cls_t            cls_in, cls_q;
    logic [1:0]      size_q;

    logic            pc_write_raw, ir_write_raw, jump_raw, branch_raw;
    logic            mem_to_reg_raw, reg_write_raw, fault_raw;
    logic [1:0]      reg_dst_raw, mem_read_raw, mem_write_raw, alu_src_raw;
    logic [ALUW-1:0] alu_op_raw;

    generate
        if (OPW > 6) begin : g_upper
            assign upper_nz = |bus.opcode[OPW-1:6];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign cls_in = upper_nz ? C_ILL : classify(bus.opcode[5:0]);
    assign cls_q  = classify(op_reg);
    assign size_q = access_code(op_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            op_reg    <= '0;
            cnt_reg   <= '0;
            cause_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            cause_reg <= cause_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        cnt_next       = cnt_reg;
        cause_next     = cause_reg;
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        reg_dst_raw    = 2'b00;
        jump_raw       = 1'b0;
        branch_raw     = 1'b0;
        mem_read_raw   = 2'b00;
        mem_write_raw  = 2'b00;
        mem_to_reg_raw = 1'b0;
        alu_op_raw     = '0;
        alu_src_raw    = 2'b00;
        reg_write_raw  = 1'b0;
        fault_raw      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                if (bus.imem_ready && !bus.stall) begin
                    pc_write_raw = 1'b1;
                    ir_write_raw = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!bus.stall) begin
                    op_next = bus.opcode[5:0];
                    if (cls_in == C_ILL) begin
                        fault_raw  = 1'b1;
                        cause_next = 2'b01;
                        state_next = S_FETCH;
                    end else if (cls_in == C_NOP) begin
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_op_raw = (cls_q == C_R) ? {ALUW{1'b1}} : ALUW'(op_reg);
                case (cls_q)
                    C_IMM:       begin alu_src_raw = 2'b01; reg_dst_raw = 2'b01; end
                    C_BR:        begin branch_raw = 1'b1; alu_src_raw = 2'b10; end
                    C_J:         jump_raw = 1'b1;
                    C_JAL:       begin jump_raw = 1'b1; reg_dst_raw = 2'b10; end
                    C_LD, C_ST:  alu_src_raw = 2'b01;
                    default:     ;
                endcase
                if (!bus.stall) begin
                    case (cls_q)
                        C_R, C_IMM, C_JAL: state_next = S_WB;
                        C_LD, C_ST:        state_next = S_MEM;
                        default:           state_next = S_FETCH;
                    endcase
                end
            end
            S_MEM: begin
                // Hazard stall has no effect here; only the memory decides when we leave.
                alu_op_raw  = ALUW'(op_reg);
                alu_src_raw = 2'b01;
                if (cls_q == C_LD) mem_read_raw  = size_q;
                if (cls_q == C_ST) mem_write_raw = size_q;
                if (bus.dmem_ready) begin
                    cnt_next   = '0;
                    state_next = (cls_q == C_LD) ? S_WB : S_FETCH;
                end else if (cnt_reg == CNT_LAST) begin
                    fault_raw  = 1'b1;
                    cause_next = 2'b10;
                    cnt_next   = '0;
                    state_next = S_FETCH;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WB: begin
                reg_write_raw  = !bus.stall;
                mem_to_reg_raw = (cls_q == C_LD);
                case (cls_q)
                    C_IMM, C_LD: reg_dst_raw = 2'b01;
                    C_JAL:       reg_dst_raw = 2'b10;
                    default:     reg_dst_raw = 2'b00;
                endcase
                if (!bus.stall) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Reset must silence the Mealy terms (FETCH enables, fault) without waiting for a clock.
    assign bus.pc_write    = pc_write_raw & ~reset;
    assign bus.ir_write    = ir_write_raw & ~reset;
    assign bus.reg_dst     = reset ? 2'b00 : reg_dst_raw;
    assign bus.jump        = jump_raw & ~reset;
    assign bus.branch      = branch_raw & ~reset;
    assign bus.mem_read    = reset ? 2'b00 : mem_read_raw;
    assign bus.mem_write   = reset ? 2'b00 : mem_write_raw;
    assign bus.mem_to_reg  = mem_to_reg_raw & ~reset;
    assign bus.alu_op      = reset ? '0 : alu_op_raw;
    assign bus.alu_src     = reset ? 2'b00 : alu_src_raw;
    assign bus.reg_write   = reg_write_raw & ~reset;
    assign bus.busy        = (state_reg != S_FETCH) & ~reset;
    assign bus.fault       = fault_raw & ~reset;
    assign bus.fault_cause = cause_reg;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected control traces built from the
// instruction-class rules, played cycle by cycle against the DUT.
module tb_multicycle_control_unit;
    localparam int OPW  = 8;
    localparam int ALUW = 8;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OPW(OPW), .ALUW(ALUW)) bus ();

    multicycle_control_unit #(.OPW(OPW), .ALUW(ALUW), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {K_ILL, K_NOP, K_R, K_IMM, K_BR, K_J, K_JAL, K_LD, K_ST} kind_t;

    typedef struct packed {
        logic            pc_write;
        logic            ir_write;
        logic [1:0]      reg_dst;
        logic            jump;
        logic            branch;
        logic [1:0]      mem_read;
        logic [1:0]      mem_write;
        logic            mem_to_reg;
        logic [ALUW-1:0] alu_op;
        logic [1:0]      alu_src;
        logic            reg_write;
        logic            busy;
        logic            fault;
    } obs_t;

    typedef struct {
        obs_t e;
        byte  ph;
        bit   dmem;
    } step_t;

    int checks = 0;
    int errors = 0;
    int txn_id = 0;
    logic [1:0] cause_model = 2'b00;

    logic [5:0] legal_ops [20] = '{
        6'b000000, 6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001101, 6'b010011,
        6'b001010, 6'b001011, 6'b001100, 6'b010101, 6'b010110, 6'b010111,
        6'b001110, 6'b001111, 6'b010100, 6'b010000, 6'b010001, 6'b010010, 6'b100000
    };

    function automatic kind_t kind_of(input logic [OPW-1:0] op);
        if (op[OPW-1:6] != '0) return K_ILL;
        case (op[5:0])
            6'b000000: return K_R;
            6'b100000: return K_NOP;
            6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001101, 6'b010011: return K_IMM;
            6'b001010, 6'b001011, 6'b001100: return K_BR;
            6'b010101, 6'b010110: return K_J;
            6'b010111: return K_JAL;
            6'b001110, 6'b001111, 6'b010100: return K_LD;
            6'b010000, 6'b010001, 6'b010010: return K_ST;
            default: return K_ILL;
        endcase
    endfunction

    // LH 01, LW 10, LB 11 on mem_read; SB 01, SH 10, SW 11 on mem_write.
    function automatic logic [1:0] size_of(input logic [5:0] op);
        case (op)
            6'b001110: return 2'b01;
            6'b001111: return 2'b10;
            6'b010100: return 2'b11;
            6'b010000: return 2'b01;
            6'b010001: return 2'b10;
            6'b010010: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc_write   = bus.pc_write;
        o.ir_write   = bus.ir_write;
        o.reg_dst    = bus.reg_dst;
        o.jump       = bus.jump;
        o.branch     = bus.branch;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.mem_to_reg = bus.mem_to_reg;
        o.alu_op     = bus.alu_op;
        o.alu_src    = bus.alu_src;
        o.reg_write  = bus.reg_write;
        o.busy       = bus.busy;
        o.fault      = bus.fault;
        return o;
    endfunction

    // One instruction: waits = dmem_ready-low cycles in MEM (>= TMO means never ready),
    // stall_len cycles of stall inserted before step stall_at (-1 picks a random non-MEM step).
    task automatic run_txn(input logic [OPW-1:0] op, input int waits, input int stall_len,
                           input int stall_at, input bit mem_noise);
        step_t steps[$];
        step_t s;
        kind_t k;
        logic [5:0] op6;
        obs_t exp, obs;
        int sidx, ncyc, errs0, n_mem;
        bit timeout;
        k = kind_of(op);
        op6 = op[5:0];
        errs0 = errors;
        ncyc = 0;
        timeout = (k == K_LD || k == K_ST) && waits >= TMO;

        s.dmem = 1'b0;
        s.e = '0; s.e.pc_write = 1'b1; s.e.ir_write = 1'b1; s.ph = "F";
        steps.push_back(s);
        s.e = '0; s.e.busy = 1'b1; s.e.fault = (k == K_ILL); s.ph = "D";
        steps.push_back(s);
        if (k != K_ILL && k != K_NOP) begin
            s.e = '0; s.e.busy = 1'b1; s.ph = "E";
            s.e.alu_op  = (k == K_R) ? {ALUW{1'b1}} : ALUW'(op6);
            s.e.alu_src = (k == K_BR) ? 2'b10 : (k inside {K_IMM, K_LD, K_ST}) ? 2'b01 : 2'b00;
            s.e.reg_dst = (k == K_IMM) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
            s.e.branch  = (k == K_BR);
            s.e.jump    = (k == K_J || k == K_JAL);
            steps.push_back(s);
            if (k == K_LD || k == K_ST) begin
                n_mem = timeout ? TMO : waits + 1;
                for (int i = 0; i < n_mem; i++) begin
                    s.e = '0; s.e.busy = 1'b1; s.ph = "M";
                    s.e.alu_op    = ALUW'(op6);
                    s.e.alu_src   = 2'b01;
                    s.e.mem_read  = (k == K_LD) ? size_of(op6) : 2'b00;
                    s.e.mem_write = (k == K_ST) ? size_of(op6) : 2'b00;
                    s.e.fault     = timeout && (i == n_mem - 1);
                    s.dmem        = (i == waits);
                    steps.push_back(s);
                end
                s.dmem = 1'b0;
            end
            if (k inside {K_R, K_IMM, K_JAL} || (k == K_LD && !timeout)) begin
                s.e = '0; s.e.busy = 1'b1; s.e.reg_write = 1'b1; s.ph = "W";
                s.e.mem_to_reg = (k == K_LD);
                s.e.reg_dst = (k == K_JAL) ? 2'b10 : (k == K_R) ? 2'b00 : 2'b01;
                steps.push_back(s);
            end
        end

        sidx = stall_at;
        if (stall_len > 0 && sidx < 0) begin
            sidx = $urandom_range(1, steps.size() - 1);
            if (steps[sidx].ph == "M") sidx = 1;
        end

        for (int j = 0; j < steps.size(); j++) begin
            if (stall_len > 0 && j == sidx) begin
                for (int c = 0; c < stall_len; c++) begin
                    exp = steps[j].e;
                    exp.pc_write = 1'b0; exp.ir_write = 1'b0;
                    exp.reg_write = 1'b0; exp.fault = 1'b0;
                    bus.stall = 1'b1;
                    bus.imem_ready = 1'($urandom);
                    bus.dmem_ready = 1'($urandom);
                    bus.opcode = (steps[j].ph == "D") ? op : OPW'($urandom);
                    @(negedge clk);
                    obs = sample();
                    checks++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL stall_%c txn=%0d op=%h cyc=%0d got=%h required=%h",
                                 steps[j].ph, txn_id, op, ncyc, obs, exp);
                    end
                    @(posedge clk); #1;
                    ncyc++;
                end
            end
            exp = steps[j].e;
            bus.stall      = (steps[j].ph == "M" && mem_noise) ? 1'($urandom) : 1'b0;
            bus.imem_ready = (steps[j].ph == "F") ? 1'b1 : 1'($urandom);
            bus.dmem_ready = (steps[j].ph == "M") ? steps[j].dmem : 1'($urandom);
            bus.opcode     = (steps[j].ph == "F" || steps[j].ph == "D") ? op : OPW'($urandom);
            @(negedge clk);
            obs = sample();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL step_%c txn=%0d op=%h cyc=%0d got=%h required=%h",
                         steps[j].ph, txn_id, op, ncyc, obs, exp);
            end
            @(posedge clk); #1;
            ncyc++;
        end

        if (k == K_ILL) cause_model = 2'b01;
        else if (timeout) cause_model = 2'b10;

        bus.imem_ready = 1'b0;
        bus.stall      = 1'($urandom);
        bus.dmem_ready = 1'($urandom);
        @(negedge clk);
        obs = sample();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL idle txn=%0d op=%h got=%h required=%h", txn_id, op, obs, obs_t'(0));
        end
        checks++;
        if (bus.fault_cause !== cause_model) begin
            errors++;
            $display("FAIL fault_cause txn=%0d op=%h got=%b required=%b",
                     txn_id, op, bus.fault_cause, cause_model);
        end
        @(posedge clk); #1;
        $display("txn %0d op=%h kind=%0d waits=%0d stall=%0d cycles=%0d new_errors=%0d",
                 txn_id, op, k, waits, stall_len, ncyc, errors - errs0);
        txn_id++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 8'h06; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.stall = 1'b0;
        @(negedge clk);
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", sample());
        end
        checks++;
        if (bus.fault_cause !== 2'b00) begin
            errors++;
            $display("FAIL reset_fault_cause got=%b required=00", bus.fault_cause);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        bus.imem_ready = 1'b0;
        cause_model = 2'b00;
    endtask

    task automatic test_fetch_stall();
        for (int c = 0; c < 5; c++) begin
            bus.imem_ready = (c < 3);
            bus.stall = (c < 3);
            @(negedge clk);
            checks++;
            if (sample() !== '0) begin
                errors++;
                $display("FAIL fetch_hold cyc=%0d got=%h required=0", c, sample());
            end
            @(posedge clk); #1;
        end
        run_txn(8'h00, 0, 0, -1, 1'b0);
    endtask

    task automatic test_alu();
        run_txn(8'h06, 0, 0, -1, 1'b0);   // ADDI
        run_txn(8'h13, 0, 0, -1, 1'b0);   // LUI
        run_txn(8'h00, 0, 0, -1, 1'b0);   // R-type
        run_txn(8'h17, 0, 0, -1, 1'b0);   // JAL
        run_txn(8'h16, 0, 0, -1, 1'b0);   // J
        run_txn(8'h20, 0, 0, -1, 1'b0);   // NOP
    endtask

    task automatic test_memory();
        run_txn(8'h0F, 3, 0, -1, 1'b1);       // LW, ready late
        run_txn(8'h11, 0, 0, -1, 1'b0);       // SH, immediate ready
        run_txn(8'h14, TMO - 1, 0, -1, 1'b1); // LB, ready on the final allowed cycle
        run_txn(8'h12, TMO, 0, -1, 1'b1);     // SW timeout
        run_txn(8'h0E, TMO + 2, 0, -1, 1'b0); // LH timeout
    endtask

    task automatic test_illegal();
        run_txn(8'h38, 0, 0, -1, 1'b0);
        run_txn(8'h12, 1, 0, -1, 1'b0);
        run_txn(8'h46, 0, 0, -1, 1'b0);   // upper bit set on an otherwise legal opcode
        run_txn(8'h3F, 0, 2, 1, 1'b0);    // stalled in DECODE before faulting
    endtask

    task automatic test_stall_branch();
        run_txn(8'h0A, 0, 2, 2, 1'b0);    // BEQ frozen in EXEC
        run_txn(8'h08, 0, 3, 3, 1'b0);    // immediate ALU frozen in WB
        run_txn(8'h0F, 2, 2, 2, 1'b1);    // LW stalled in EXEC, stall noise in MEM
    endtask

    task automatic test_reset_mid_mem();
        obs_t obs;
        bus.opcode = 8'h14; bus.imem_ready = 1'b1; bus.stall = 1'b0; bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.mem_read !== 2'b11 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lb_in_mem got=%b/%b required=11/1", bus.mem_read, bus.busy);
        end
        #2 reset = 1'b1;
        #1;
        obs = sample();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_mid_mem got=%h required=0", obs);
        end
        checks++;
        if (bus.fault_cause !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_mem_cause got=%b required=00", bus.fault_cause);
        end
        cause_model = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("txn %0d op=14 reset during MEM", txn_id);
        txn_id++;
        run_txn(8'h06, 0, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [OPW-1:0] op;
        int w, sl;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) op = {2'b00, legal_ops[$urandom_range(0, 19)]};
            else op = OPW'($urandom);
            case ($urandom_range(0, 7))
                0:       w = TMO + int'($urandom_range(0, 2));
                1:       w = TMO - 1;
                default: w = int'($urandom_range(0, 4));
            endcase
            sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(op, w, sl, -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_alu();
        test_memory();
        test_illegal();
        test_stall_branch();
        test_memory();
        test_reset_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
